// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage integer pipeline.
// Resolves load-use, redirect and data-memory-wait hazards and keeps performance counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             sclr,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic             use_rs1D,
    input  logic             use_rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             memreadE,
    input  logic             redirectE,
    input  logic [4:0]       rdM,
    input  logic             regwriteM,
    input  logic             dmem_reqM,
    input  logic             dmem_readyM,
    input  logic [4:0]       rdW,
    input  logic             regwriteW,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam logic [1:0] BOOT    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] MEMWAIT = 2'd2;

    localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

    logic [1:0]      state;
    logic [1:0]      next_state;
    logic [TO_W-1:0] wait_cnt;
    logic            lu;
    logic            mw;
    logic            run_eval;
    logic            go_wait;
    logic            wait_inc;
    logic            timeout;
    logic            redir_flush;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (regwriteM && rdM != 5'd0 && rdM == rs)
            return 2'b10;
        else if (regwriteW && rdW != 5'd0 && rdW == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign fwdAE = fwd_sel(rs1E);
    assign fwdBE = fwd_sel(rs2E);

    assign lu = memreadE && rdE != 5'd0 &&
                ((use_rs1D && rdE == rs1D) || (use_rs2D && rdE == rs2D));
    assign mw = dmem_reqM && !dmem_readyM;

    always_comb begin
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushW      = 1'b0;
        next_state  = state;
        run_eval    = 1'b0;
        go_wait     = 1'b0;
        wait_inc    = 1'b0;
        timeout     = 1'b0;
        redir_flush = 1'b0;
        case (state)
            BOOT: begin
                stallF     = 1'b1;
                flushD     = 1'b1;
                flushE     = 1'b1;
                flushW     = 1'b1;
                next_state = RUN;
            end
            RUN: run_eval = 1'b1;
            MEMWAIT: begin
                // A dropped request counts as completion, so only mw keeps us waiting.
                if (mw) begin
                    if (wait_cnt == TIMEOUT_VAL) begin
                        timeout    = 1'b1;
                        flushW     = 1'b1;
                        next_state = RUN;
                    end else begin
                        stallF   = 1'b1;
                        stallD   = 1'b1;
                        stallE   = 1'b1;
                        stallM   = 1'b1;
                        flushW   = 1'b1;
                        wait_inc = 1'b1;
                    end
                end else begin
                    run_eval   = 1'b1;
                    next_state = RUN;
                end
            end
            default: next_state = BOOT;
        endcase

        if (run_eval) begin
            if (mw) begin
                stallF     = 1'b1;
                stallD     = 1'b1;
                stallE     = 1'b1;
                stallM     = 1'b1;
                flushW     = 1'b1;
                go_wait    = 1'b1;
                next_state = MEMWAIT;
            end else if (redirectE) begin
                flushD      = 1'b1;
                flushE      = 1'b1;
                redir_flush = 1'b1;
            end else if (lu) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state     <= BOOT;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else if (sclr) begin
            state     <= BOOT;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (go_wait)
                wait_cnt <= TO_W'(1);
            else if (wait_inc)
                wait_cnt <= wait_cnt + 1'b1;
            if (stallF && state != BOOT)
                stall_cnt <= sat_inc(stall_cnt);
            if (redir_flush)
                flush_cnt <= sat_inc(flush_cnt);
            if (timeout)
                mem_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, built with 4-bit counters and a short memory timeout.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int TO_W  = 8;
    localparam int MTO   = 20;

    localparam logic [6:0] C_BOOT = 7'b1000111;
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_RED  = 7'b0000110;
    localparam logic [6:0] C_WAIT = 7'b1111001;
    localparam logic [6:0] C_TO   = 7'b0000001;

    logic             clk = 1'b0;
    logic             aclr, sclr;
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             use_rs1D, use_rs2D, memreadE, redirectE;
    logic             regwriteM, dmem_reqM, dmem_readyM, regwriteW;
    logic             stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]       fwdAE, fwdBE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_err;
    logic [6:0]       ctl;

    int tests_run = 0;
    int tests_failed = 0;

    assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W), .MEM_TIMEOUT(MTO)) dut (
        .clk(clk), .aclr(aclr), .sclr(sclr),
        .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .memreadE(memreadE), .redirectE(redirectE),
        .rdM(rdM), .regwriteM(regwriteM), .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
        .rdW(rdW), .regwriteW(regwriteW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .fwdAE(fwdAE), .fwdBE(fwdBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        sclr = 0; rs1D = 0; rs2D = 0; use_rs1D = 0; use_rs2D = 0;
        rs1E = 0; rs2E = 0; rdE = 0; memreadE = 0; redirectE = 0;
        rdM = 0; regwriteM = 0; dmem_reqM = 0; dmem_readyM = 0;
        rdW = 0; regwriteW = 0;
    endtask

    // Advance to just after the next rising edge, where new inputs are applied.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        aclr = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 aclr = 1;
        sample();
        check("boot_ctl", 32'(ctl), 32'(C_BOOT));
        check("boot_fwd", 32'({fwdAE, fwdBE}), 0);
        check("boot_scnt", 32'(stall_cnt), 0);
        check("boot_fcnt", 32'(flush_cnt), 0);
        check("boot_err", 32'(mem_err), 0);

        next_cycle();
        sample();
        check("run_idle", 32'(ctl), 32'(C_NONE));
        check("run_scnt", 32'(stall_cnt), 0);

        next_cycle();
        memreadE = 1; rdE = 5; use_rs1D = 1; rs1D = 5;
        sample();
        check("lu_ctl", 32'(ctl), 32'(C_LU));
        next_cycle();
        clear_inputs();
        sample();
        check("lu_clear", 32'(ctl), 32'(C_NONE));
        check("lu_scnt", 32'(stall_cnt), 1);

        next_cycle();
        memreadE = 1; rdE = 0; use_rs1D = 1; rs1D = 0;
        sample();
        check("lu_x0", 32'(ctl), 32'(C_NONE));

        next_cycle();
        clear_inputs();
        use_rs2D = 1; rs2D = 9; memreadE = 1; rdE = 9;
        sample();
        check("lu_rs2", 32'(ctl), 32'(C_LU));

        next_cycle();
        clear_inputs();
        regwriteM = 1; rdM = 7; regwriteW = 1; rdW = 7; rs1E = 7; rs2E = 3;
        sample();
        check("fwdA_m", 32'(fwdAE), 2);
        check("fwdB_none", 32'(fwdBE), 0);
        next_cycle();
        regwriteM = 0;
        sample();
        check("fwdA_w", 32'(fwdAE), 1);
        next_cycle();
        regwriteM = 1; rdM = 0; rs2E = 0; rdW = 0;
        sample();
        check("fwdA_x0", 32'(fwdAE), 0);
        check("fwdB_x0", 32'(fwdBE), 0);
        next_cycle();
        clear_inputs();
        regwriteM = 1; rdM = 4; regwriteW = 1; rdW = 6; rs1E = 6; rs2E = 4;
        sample();
        check("fwdA_w2", 32'(fwdAE), 1);
        check("fwdB_m2", 32'(fwdBE), 2);
        check("stall_cnt_2", 32'(stall_cnt), 2);

        next_cycle();
        clear_inputs();
        redirectE = 1; memreadE = 1; rdE = 5; use_rs1D = 1; rs1D = 5;
        sample();
        check("red_lu_ctl", 32'(ctl), 32'(C_RED));
        next_cycle();
        clear_inputs();
        sample();
        check("red_fcnt", 32'(flush_cnt), 1);
        check("red_scnt", 32'(stall_cnt), 2);

        // Three-cycle memory wait with a redirect held across it.
        next_cycle();
        dmem_reqM = 1; dmem_readyM = 0; redirectE = 1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("wait_ctl%0d", i), 32'(ctl), 32'(C_WAIT));
            next_cycle();
        end
        dmem_readyM = 1;
        sample();
        check("wait_ready", 32'(ctl), 32'(C_RED));
        check("wait_scnt", 32'(stall_cnt), 5);
        check("wait_fcnt", 32'(flush_cnt), 1);
        next_cycle();
        clear_inputs();
        sample();
        check("wait_done", 32'(ctl), 32'(C_NONE));
        check("wait_fcnt2", 32'(flush_cnt), 2);

        // Never-ready access: MTO stall cycles, then release with saturated counter.
        next_cycle();
        dmem_reqM = 1;
        for (int i = 0; i < MTO; i++) begin
            sample();
            check($sformatf("to_ctl%0d", i), 32'(ctl), 32'(C_WAIT));
            next_cycle();
        end
        sample();
        check("to_release", 32'(ctl), 32'(C_TO));
        check("to_err_pre", 32'(mem_err), 0);
        next_cycle();
        dmem_reqM = 0;
        sample();
        check("to_err", 32'(mem_err), 1);
        check("to_run", 32'(ctl), 32'(C_NONE));
        check("scnt_sat", 32'(stall_cnt), 15);
        next_cycle();
        memreadE = 1; rdE = 5; use_rs1D = 1; rs1D = 5;
        sample();
        check("sat_lu", 32'(ctl), 32'(C_LU));
        next_cycle();
        clear_inputs();
        sample();
        check("scnt_hold", 32'(stall_cnt), 15);
        check("err_sticky", 32'(mem_err), 1);

        // Synchronous clear in the middle of a memory wait.
        next_cycle();
        dmem_reqM = 1;
        next_cycle();
        sclr = 1;
        sample();
        check("sclr_pre", 32'(ctl), 32'(C_WAIT));
        next_cycle();
        clear_inputs();
        sample();
        check("sclr_boot", 32'(ctl), 32'(C_BOOT));
        check("sclr_scnt", 32'(stall_cnt), 0);
        check("sclr_fcnt", 32'(flush_cnt), 0);
        check("sclr_err", 32'(mem_err), 0);
        next_cycle();
        sample();
        check("sclr_run", 32'(ctl), 32'(C_NONE));
        check("sclr_boot_nocnt", 32'(stall_cnt), 0);

        // Asynchronous reset during a load-use bubble.
        next_cycle();
        memreadE = 1; rdE = 8; use_rs2D = 1; rs2D = 8;
        #2 aclr = 0;
        #1;
        check("aclr_boot", 32'(ctl), 32'(C_BOOT));
        next_cycle();
        aclr = 1;
        clear_inputs();
        sample();
        check("aclr_hold", 32'(ctl), 32'(C_BOOT));
        next_cycle();
        sample();
        check("aclr_run", 32'(ctl), 32'(C_NONE));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forward sequencer for the 5-stage integer pipeline.
- Drives the sclr/enable inputs of the F/D, D/E, E/M and M/W pipeline registers and the E-stage operand forwarding muxes.
- Resolves load-use hazards, taken-branch/jump redirects and multi-cycle data-memory waits.
- Keeps saturating stall/flush performance counters and a memory-timeout error flag.

Parameters:
- CNT_W, 16, width of the performance counters stall_cnt and flush_cnt.
- TO_W, 8, width of the memory-wait timeout counter.
- MEM_TIMEOUT, 200, wait cycles before the memory timeout fires; must be < 2^TO_W.

Ports:
- clk  in  1  pipeline clock, rising edge.
- aclr  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear, active-high: same effect as aclr on the next edge.
- rs1D, rs2D  in  5  source registers of the instruction in D.
- use_rs1D, use_rs2D  in  1  the D instruction actually reads rs1/rs2.
- rs1E, rs2E, rdE  in  5  source and destination registers in E.
- memreadE  in  1  the E instruction is a load.
- redirectE  in  1  a branch was taken or a jump resolved in E.
- rdM  in  5  destination register in M.
- regwriteM  in  1  the M instruction writes the register file.
- dmem_reqM  in  1  the M instruction accesses data memory.
- dmem_readyM  in  1  data memory completes the access this cycle.
- rdW  in  5  destination register in W.
- regwriteW  in  1  the W instruction writes the register file.
- stallF, stallD, stallE, stallM  out  1  hold the corresponding stage register or PC.
- flushD, flushE, flushW  out  1  sclr to the F/D, D/E and M/W registers.
- fwdAE, fwdBE  out  2  operand select: 00 = register file, 01 = W result, 10 = M result.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- States: BOOT, RUN, MEMWAIT. aclr low, or sclr high at an edge, sets state = BOOT and clears wait_cnt, stall_cnt, flush_cnt and mem_err.
- Control outputs are combinational from state and inputs. Counters and mem_err are registered.
- BOOT, exactly one cycle: flushD = flushE = flushW = 1, stallF = 1, all other stalls 0, fwd = 00. Next state RUN. No counters increment.
- Reset values, as seen while in BOOT: stallF = 1, flushD = flushE = flushW = 1, stallD = stallE = stallM = 0, fwdAE = fwdBE = 00, counters 0, mem_err 0.
- Forwarding, in every state:
  - fwdAE = 10 if regwriteM & rdM != 0 & rdM == rs1E.
  - Otherwise fwdAE = 01 if regwriteW & rdW != 0 & rdW == rs1E.
  - Otherwise fwdAE = 00. fwdBE is the same using rs2E. M has priority over W.
- Load-use condition: lu = memreadE & rdE != 0 & ((use_rs1D & rdE == rs1D) | (use_rs2D & rdE == rs2D)).
- Memory wait condition: mw = dmem_reqM & !dmem_readyM.
- RUN, priority order:
  1. mw: stallF = stallD = stallE = stallM = 1, flushW = 1. Go to MEMWAIT, wait_cnt <= 1. Any redirectE or lu is held and re-evaluated after the wait.
  2. redirectE: flushD = flushE = 1, no stalls. lu is ignored because the D instruction is squashed.
  3. lu: stallF = stallD = 1, flushE = 1. Exactly one bubble, since lu clears once the load moves to M.
  4. Otherwise all stall/flush outputs are 0.
- MEMWAIT:
  - While !dmem_readyM: all four stalls = 1, flushW = 1, wait_cnt increments.
  - When dmem_readyM = 1: stalls drop in that same cycle, RUN priority rules apply to the other inputs, next state RUN.
  - When wait_cnt == MEM_TIMEOUT and still not ready: mem_err <= 1 (sticky until reset), stalls released, flushW = 1, next state RUN, pipeline resumes.
  - dmem_reqM dropping while in MEMWAIT is treated as ready.
- Counters:
  - stall_cnt increments on each cycle stallF = 1 outside BOOT.
  - flush_cnt increments on each cycle redirectE causes flushD.
  - Both saturate at all-ones and never wrap.
- Mid-operation reset: aclr in MEMWAIT or during a load-use bubble goes straight to BOOT. No pending hazard survives.
- An x0 destination never causes forwarding or load-use stalls.

Test Plan:
- Release aclr -> one BOOT cycle with stallF = 1 and flushD/E/W = 1; next cycle all 0; counters = 0.
- lw x5 in E (memreadE = 1, rdE = 5), D uses rs1D = 5 -> one cycle stallF = stallD = flushE = 1, then clear; stall_cnt = 1. Same case with rdE = 0 -> no stall.
- regwriteM and regwriteW both with rd = 7, rs1E = 7 -> fwdAE = 10. Drop regwriteM -> fwdAE = 01.
- redirectE and lu in the same cycle -> flushD = flushE = 1, stallF = 0; flush_cnt += 1.
- dmem_reqM = 1 with ready low for 3 cycles, then high -> 3 cycles of all stalls and flushW = 1; stalls drop on the ready cycle; stall_cnt += 3. Repeat with ready never asserted -> after MEM_TIMEOUT cycles mem_err = 1 and stalls release.
- Force stall_cnt to all-ones via a long memory wait (CNT_W = 4 build) -> holds at 15. Assert sclr mid-MEMWAIT -> next cycle BOOT, counters 0, mem_err 0.
